// File: rtl/rs232_rx.sv
// UART receiver recovering 8N1 frames (8E1 when RS232_RX_PARITY_EN is defined) from an
// asynchronous serial line, sampled at mid-bit against a fixed clocks-per-bit divider.
module rs232_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       DONE,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef RS232_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`endif

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;
    state_t                 state_r, state_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic [2:0]             idx_r, idx_s;
    logic [7:0]             shift_r, shift_s;
    logic [7:0]             data_r, data_s;
    logic                   done_r, done_s;
    logic                   ferr_r, ferr_s;
    logic                   busy_r;
    logic                   par_good_s;

    // Metastability synchronizer, preset to the idle (high) line level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], RX};
        end
    end

    assign rxs_s = sync_r[SYNC_STAGES-1];

`ifdef RS232_RX_PARITY_EN
    logic par_ok_r, par_ok_s;
    assign par_good_s = par_ok_r;
`else
    assign par_good_s = 1'b1;
`endif

    // Next-state and datapath decode for the receive FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        data_s  = data_r;
        done_s  = 1'b0;
        ferr_s  = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_ok_s = par_ok_r;
`endif
        unique case (state_r)
            S_IDLE: begin
                cnt_s = CNT_ZERO;
                idx_s = 3'd0;
                if (!rxs_s) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                // A low pulse that is gone by mid start bit is treated as a glitch.
                if (cnt_r == CNT_MID) begin
                    cnt_s = CNT_ZERO;
                    if (rxs_s) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_r == CNT_END) begin
                    cnt_s          = CNT_ZERO;
                    shift_s[idx_r] = rxs_s;
                    if (idx_r == 3'd7) begin
                        idx_s = 3'd0;
`ifdef RS232_RX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`ifdef RS232_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_r == CNT_END) begin
                    cnt_s    = CNT_ZERO;
                    par_ok_s = (rxs_s == even_parity(shift_r));
                    state_s  = S_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop gives half a bit of margin for a back-to-back start edge.
                if (cnt_r == CNT_END) begin
                    cnt_s = CNT_ZERO;
                    if (rxs_s && par_good_s) begin
                        data_s  = shift_r;
                        done_s  = 1'b1;
                        state_s = S_IDLE;
                    end else if (rxs_s) begin
                        ferr_s  = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = S_BREAK;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_BREAK: begin
                // A held-low line reports one error, then waits for the line to recover.
                cnt_s = CNT_ZERO;
                if (rxs_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_BREAK;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
                idx_s   = 3'd0;
            end
        endcase
    end

    // FSM state, datapath and registered output flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            done_r  <= done_s;
            ferr_r  <= ferr_s;
            busy_r  <= (state_s != S_IDLE);
        end
    end

`ifdef RS232_RX_PARITY_EN
    // Parity verdict held from the parity bit until the stop bit decision.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_ok_r <= 1'b0;
        end else begin
            par_ok_r <= par_ok_s;
        end
    end
`endif

    assign DATA      = data_r;
    assign DONE      = done_r;
    assign FRAME_ERR = ferr_r;
    assign BUSY      = busy_r;

endmodule

// File: doc/rs232_rx.md
Name: rs232_rx

Overview:
- UART receiver, the mirror of rs232_tx. Recovers 8N1 frames from the asynchronous serial input RX.
- Presents each received byte on DATA with a one-cycle DONE pulse.
- Sits between the board RS-232 pin and the scoreboard command logic.
- Samples RX against a fixed CLK-cycles-per-bit divider and takes each sample at mid-bit.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per serial bit. Must be >= 4. Bench uses 16.
- SYNC_STAGES, 2, flip-flop stages in the RX metastability synchronizer. Range 2..4.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is used synchronously.
- RX  input  1  serial line, idle high, LSB first.
- DATA  output  8  last good received byte; holds until the next good frame.
- DONE  output  1  one-cycle pulse when DATA updates.
- FRAME_ERR  output  1  one-cycle pulse on a bad stop bit (or bad parity if enabled).
- BUSY  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset values: DATA=8'h00, DONE=0, FRAME_ERR=0, BUSY=0, state=IDLE, synchronizer preset to 1 (idle line).
- RX passes through SYNC_STAGES flops. "rxs" below is the synchronized value.
- Bit counter: clog2(CLKS_PER_BIT) bits. Index counter: 3 bits, wraps 7->0 only on state exit.
- IDLE:
  - rxs==0 -> START, counter cleared.
- START:
  - At count CLKS_PER_BIT/2-1 (mid start bit), rxs is re-sampled.
  - rxs==1 -> false start: back to IDLE, no pulse.
  - rxs==0 -> DATA, counter cleared.
- DATA:
  - Every CLKS_PER_BIT cycles, rxs is shifted into the shift register at bit[index], LSB first.
  - After index 7 -> STOP (or PARITY when the option is enabled).
- STOP, sampled at mid-bit:
  - rxs==1: DATA<=shift register, DONE=1 for exactly one cycle, then -> IDLE.
  - rxs==0: FRAME_ERR=1 for one cycle, DATA unchanged, then -> BREAK.
- BREAK:
  - Waits for rxs==1, then -> IDLE.
  - A held-low line yields exactly one FRAME_ERR, not repeated frames.
- Latency:
  - DONE asserts 1 cycle after the mid-stop sample.
  - Total is about 9.5 bit times + SYNC_STAGES + 1 cycles from the RX falling edge.
- Back-to-back frames:
  - Returning to IDLE at mid-stop leaves half a bit of margin.
  - A start edge immediately after the stop bit must be caught; no idle gap is required.
- DONE and FRAME_ERR are never high in the same cycle.
- Glitch: a low pulse shorter than CLKS_PER_BIT/2 cycles is rejected by the START check.
- Reset mid-frame: immediate return to the reset state. The partial byte is discarded; no DONE or FRAME_ERR.

Optional Feature:
- Macro RS232_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. After DATA, the FSM enters PARITY and samples one extra bit.
  - The received bit must equal the XOR of the 8 data bits (even parity).
  - On mismatch, the stop bit is still sampled, then FRAME_ERR pulses and DATA is not updated; no DONE.
- Undefined:
  - 8N1. The PARITY state and its logic are absent.

Test Plan:
- Reset: hold RST=0 for 3 cycles with RX toggling -> DATA=0x00, DONE=0, FRAME_ERR=0, BUSY=0 throughout.
- Single frame: 8N1 frame of 0xD2 (bits 0,1,0,0,1,0,1,1) at 16 clk/bit -> DONE pulses once for 1 cycle, DATA=0xD2, BUSY falls in the same cycle.
- Back-to-back: 0x55 then 0xAA with no idle gap -> two DONE pulses about 160 cycles apart, DATA=0x55 then 0xAA.
- False start: RX low for 5 cycles, then high -> no DONE, no FRAME_ERR; BUSY high for at most 9 cycles.
- Framing error: 0x3C sent with stop bit 0, RX then held low for 40 cycles before release -> one FRAME_ERR pulse, DATA keeps its previous value, next good frame 0x81 gives DONE with DATA=0x81.
- Reset mid-frame: RST pulsed low after data bit 3 of 0xF0 -> no pulse. A following frame of 0x0F is received correctly. With RS232_RX_PARITY_EN, 0x07 sent with parity 0 (wrong) -> FRAME_ERR, no DONE.
